// File: rtl/cc_rresp_arbiter.sv
// cc_rresp_arbiter: read-response scheduler that moves whole line entries
// from the hit-data and miss-fill show-ahead FIFOs into a small output
// buffer. The serializer drains that buffer through one FIFO-style port.
//
// Handshake semantics (all three ports are show-ahead FIFO reads):
//   the head entry is valid whenever the matching *_empty is low; a read
//   strobe (*_rden) high on a rising edge consumes exactly that head entry.
//   Here, a strobe asserted while the matching empty is high has no effect.
module cc_rresp_arbiter #(
  parameter int DEPTH      = 2,  // output buffer entries (2 or 4)
  parameter int FILL_PRIO  = 0,  // 0: round-robin, 1: fill wins ties
  parameter int MAX_STREAK = 4   // fill grants allowed while hit waits
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hit_empty_i,
  input  logic [517:0] hit_rdata_i,
  output logic         hit_rden_o,
  input  logic         fill_empty_i,
  input  logic [517:0] fill_rdata_i,
  output logic         fill_rden_o,
  output logic         ser_empty_o,
  output logic         ser_aempty_o,
  output logic [517:0] ser_rdata_o,
  output logic         ser_src_o,
  input  logic         ser_rden_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [3:0]    STREAK_C = 4'(MAX_STREAK);
  localparam logic          SRC_HIT  = 1'b0;
  localparam logic          SRC_FILL = 1'b1;

  // Buffer entry layout: {src, offset[5:0], line[511:0]}
  logic [518:0]   mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [3:0]     streak_q, streak_d;
  logic           last_grant_q, last_grant_d;

  logic           req_h, req_f;
  logic           pick_f;
  logic           grant_h, grant_f;
  logic           space;
  logic           push, pop;
  logic [518:0]   push_entry;

  // Arbitration: pick one requesting source; only honoured when space exists
  always_comb begin
    req_h   = !hit_empty_i;
    req_f   = !fill_empty_i;
    if (FILL_PRIO == 0) begin
      pick_f = (last_grant_q == SRC_HIT);
    end else begin
      pick_f = (streak_q != STREAK_C);
    end
    grant_f = req_f & (!req_h | pick_f);
    grant_h = req_h & !grant_f;
  end

  // Push/pop decode; space uses the registered count only, so a pop in the
  // same cycle never opens a slot early (refill lands one cycle later)
  always_comb begin
    space       = (count_q < DEPTH_C);
    push        = space & (grant_h | grant_f);
    pop         = ser_rden_i & (count_q != '0);
    push_entry  = grant_f ? {SRC_FILL, fill_rdata_i} : {SRC_HIT, hit_rdata_i};
    hit_rden_o  = !rst & space & grant_h;
    fill_rden_o = !rst & space & grant_f;
  end

  // Next-state for pointers, occupancy, fairness history
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    streak_d     = streak_q;
    last_grant_d = last_grant_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      last_grant_d = grant_f ? SRC_FILL : SRC_HIT;
      if (grant_f && req_h) begin
        streak_d = streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control registers; last_grant resets to fill so the first tie goes to hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      streak_q     <= '0;
      last_grant_q <= SRC_FILL;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      streak_q     <= streak_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Line storage; cleared on reset so the head reads as zero when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Serializer-facing view of the buffer head
  always_comb begin
    ser_empty_o  = (count_q == '0);
    ser_aempty_o = (count_q <= CW'(1));
    ser_rdata_o  = mem_q[rd_ptr_q][517:0];
    ser_src_o    = mem_q[rd_ptr_q][518];
  end

endmodule

// File: tb/tb_cc_rresp_arbiter.sv
// Directed bench for cc_rresp_arbiter: a round-robin instance with modelled
// source FIFOs, plus a fill-priority instance for the streak limit.
module tb_cc_rresp_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Round-robin instance signals
  logic         hit_empty, fill_empty, ser_rden;
  logic [517:0] hit_rdata, fill_rdata;
  logic         hit_rden, fill_rden, ser_empty, ser_aempty, ser_src;
  logic [517:0] ser_rdata;

  // Fill-priority instance signals
  logic         fp_hit_empty, fp_fill_empty, fp_ser_rden;
  logic [517:0] fp_hit_rdata, fp_fill_rdata;
  logic         fp_hit_rden, fp_fill_rden, fp_ser_empty, fp_ser_aempty, fp_ser_src;
  logic [517:0] fp_ser_rdata;

  // Source FIFO model: head entry is a function of how many were popped
  int           hit_cnt, fill_cnt;
  logic         use_custom;
  logic [517:0] custom_hit;

  function automatic logic [517:0] mk(input logic s, input int idx);
    logic [511:0] line;
    line = 512'(idx + 1);
    line[511:504] = s ? 8'hF1 : 8'hA1;
    mk = {6'(idx + 7), line};
  endfunction

  assign hit_rdata  = use_custom ? custom_hit : mk(1'b0, hit_cnt);
  assign fill_rdata = mk(1'b1, fill_cnt);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= 0;
      fill_cnt <= 0;
    end else begin
      if (hit_rden)  hit_cnt  <= hit_cnt + 1;
      if (fill_rden) fill_cnt <= fill_cnt + 1;
    end
  end

  cc_rresp_arbiter #(.DEPTH(2), .FILL_PRIO(0), .MAX_STREAK(4)) dut_rr (
    .clk(clk), .rst(rst),
    .hit_empty_i(hit_empty), .hit_rdata_i(hit_rdata), .hit_rden_o(hit_rden),
    .fill_empty_i(fill_empty), .fill_rdata_i(fill_rdata), .fill_rden_o(fill_rden),
    .ser_empty_o(ser_empty), .ser_aempty_o(ser_aempty), .ser_rdata_o(ser_rdata),
    .ser_src_o(ser_src), .ser_rden_i(ser_rden)
  );

  cc_rresp_arbiter #(.DEPTH(2), .FILL_PRIO(1), .MAX_STREAK(4)) dut_fp (
    .clk(clk), .rst(rst),
    .hit_empty_i(fp_hit_empty), .hit_rdata_i(fp_hit_rdata), .hit_rden_o(fp_hit_rden),
    .fill_empty_i(fp_fill_empty), .fill_rdata_i(fp_fill_rdata), .fill_rden_o(fp_fill_rden),
    .ser_empty_o(fp_ser_empty), .ser_aempty_o(fp_ser_aempty), .ser_rdata_o(fp_ser_rdata),
    .ser_src_o(fp_ser_src), .ser_rden_i(fp_ser_rden)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hit_empty = 1'b1; fill_empty = 1'b1; ser_rden = 1'b0; use_custom = 1'b0;
    fp_hit_empty = 1'b1; fp_fill_empty = 1'b1; fp_ser_rden = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (ser_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", ser_empty); end
    checks++; if (ser_aempty !== 1'b1) begin errors++; $display("FAIL rst_aempty got %b exp 1", ser_aempty); end
    checks++; if (ser_rdata !== 518'd0) begin errors++; $display("FAIL rst_rdata got %0h exp 0", ser_rdata); end
    checks++; if (ser_src !== 1'b0) begin errors++; $display("FAIL rst_src got %b exp 0", ser_src); end
    hit_empty = 1'b0;
    #1;
    checks++; if (hit_rden !== 1'b0 || fill_rden !== 1'b0) begin errors++; $display("FAIL rst_rden got %b%b exp 00", hit_rden, fill_rden); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (hit_rden !== 1'b1) begin errors++; $display("FAIL rst_first_rden got %b exp 1", hit_rden); end
    @(negedge clk);
    hit_empty = 1'b1;
    #1;
    checks++; if (ser_empty !== 1'b0) begin errors++; $display("FAIL rst_lat_empty got %b exp 0", ser_empty); end
    checks++; if (ser_rdata !== mk(1'b0, 0)) begin errors++; $display("FAIL rst_lat_data got %0h exp %0h", ser_rdata, mk(1'b0, 0)); end
  endtask

  task automatic test_single_hit();
    do_reset();
    use_custom = 1'b1;
    custom_hit = {6'd3, 448'h5A5A_C3C3_0F0F, 64'd777};
    hit_empty = 1'b0;
    #1;
    checks++; if (hit_rden !== 1'b1) begin errors++; $display("FAIL single_rden got %b exp 1", hit_rden); end
    @(negedge clk);
    hit_empty = 1'b1;
    #1;
    checks++; if (hit_rden !== 1'b0) begin errors++; $display("FAIL single_pulse got %b exp 0", hit_rden); end
    checks++; if (ser_empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", ser_empty); end
    checks++; if (ser_rdata !== custom_hit) begin errors++; $display("FAIL single_data got %0h exp %0h", ser_rdata, custom_hit); end
    checks++; if (ser_src !== 1'b0) begin errors++; $display("FAIL single_src got %b exp 0", ser_src); end
    ser_rden = 1'b1;
    @(negedge clk);
    ser_rden = 1'b0;
    #1;
    checks++; if (ser_empty !== 1'b1) begin errors++; $display("FAIL single_drain got %b exp 1", ser_empty); end
  endtask

  task automatic test_round_robin();
    logic exp_h, exp_f;
    do_reset();
    hit_empty = 1'b0; fill_empty = 1'b0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      ser_rden = ((k % 8) == 7);
      #1;
      exp_h = (k == 0) || (k == 8);
      exp_f = (k == 1) || (k == 16);
      checks++; if (hit_rden !== exp_h || fill_rden !== exp_f) begin errors++; $display("FAIL rr_grant k=%0d got %b%b exp %b%b", k, hit_rden, fill_rden, exp_h, exp_f); end
      if (k == 2) begin
        checks++; if (ser_rdata !== mk(1'b0, 0) || ser_src !== 1'b0) begin errors++; $display("FAIL rr_head2 got %b:%0h exp 0:%0h", ser_src, ser_rdata, mk(1'b0, 0)); end
      end
      if (k == 8) begin
        checks++; if (ser_rdata !== mk(1'b1, 0) || ser_src !== 1'b1) begin errors++; $display("FAIL rr_head8 got %b:%0h exp 1:%0h", ser_src, ser_rdata, mk(1'b1, 0)); end
        checks++; if (ser_aempty !== 1'b1) begin errors++; $display("FAIL rr_aempty8 got %b exp 1", ser_aempty); end
      end
      if (k == 9) begin
        checks++; if (ser_aempty !== 1'b0) begin errors++; $display("FAIL rr_aempty9 got %b exp 0", ser_aempty); end
      end
      if (k == 16) begin
        checks++; if (ser_rdata !== mk(1'b0, 1) || ser_src !== 1'b0) begin errors++; $display("FAIL rr_head16 got %b:%0h exp 0:%0h", ser_src, ser_rdata, mk(1'b0, 1)); end
      end
    end
  endtask

  task automatic test_fill_prio();
    logic exp_f, prev_f;
    do_reset();
    fp_hit_empty = 1'b0; fp_fill_empty = 1'b0; fp_ser_rden = 1'b1;
    prev_f = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_f = ((k % 5) != 4);
      checks++; if (fp_fill_rden !== exp_f || fp_hit_rden !== !exp_f) begin errors++; $display("FAIL fp_grant k=%0d got h%b f%b exp f%b", k, fp_hit_rden, fp_fill_rden, exp_f); end
      if (k > 0) begin
        checks++; if (fp_ser_src !== prev_f) begin errors++; $display("FAIL fp_src k=%0d got %b exp %b", k, fp_ser_src, prev_f); end
      end
      prev_f = exp_f;
    end
    fp_hit_empty = 1'b1; fp_fill_empty = 1'b1; fp_ser_rden = 1'b0;
  endtask

  task automatic test_full_buffer();
    do_reset();
    hit_empty = 1'b0; fill_empty = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (hit_rden !== 1'b0 || fill_rden !== 1'b0 || ser_aempty !== 1'b0) begin errors++; $display("FAIL full_idle got %b%b%b exp 000", hit_rden, fill_rden, ser_aempty); end
    @(negedge clk);
    ser_rden = 1'b1;
    #1;
    checks++; if (hit_rden !== 1'b0 || fill_rden !== 1'b0) begin errors++; $display("FAIL full_pop_rden got %b%b exp 00", hit_rden, fill_rden); end
    @(negedge clk);
    ser_rden = 1'b0;
    #1;
    checks++; if (hit_rden !== 1'b1 || fill_rden !== 1'b0) begin errors++; $display("FAIL full_refill got %b%b exp 10", hit_rden, fill_rden); end
    checks++; if (ser_src !== 1'b1 || ser_rdata !== mk(1'b1, 0)) begin errors++; $display("FAIL full_head got %b:%0h exp 1:%0h", ser_src, ser_rdata, mk(1'b1, 0)); end
    @(negedge clk);
    #1;
    checks++; if (hit_rden !== 1'b0 || fill_rden !== 1'b0 || ser_aempty !== 1'b0) begin errors++; $display("FAIL full_again got %b%b%b exp 000", hit_rden, fill_rden, ser_aempty); end
  endtask

  task automatic test_push_pop();
    do_reset();
    hit_empty = 1'b0;
    #1;
    checks++; if (hit_rden !== 1'b1) begin errors++; $display("FAIL pp_first got %b exp 1", hit_rden); end
    @(negedge clk);
    hit_empty = 1'b1; fill_empty = 1'b0; ser_rden = 1'b1;
    #1;
    checks++; if (fill_rden !== 1'b1) begin errors++; $display("FAIL pp_fill_rden got %b exp 1", fill_rden); end
    @(negedge clk);
    fill_empty = 1'b1; ser_rden = 1'b0;
    #1;
    checks++; if (ser_empty !== 1'b0 || ser_aempty !== 1'b1) begin errors++; $display("FAIL pp_count got e%b a%b exp e0 a1", ser_empty, ser_aempty); end
    checks++; if (ser_src !== 1'b1 || ser_rdata !== mk(1'b1, 0)) begin errors++; $display("FAIL pp_head got %b:%0h exp 1:%0h", ser_src, ser_rdata, mk(1'b1, 0)); end
    ser_rden = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (ser_empty !== 1'b1) begin errors++; $display("FAIL pp_drain got %b exp 1", ser_empty); end
    @(negedge clk);
    ser_rden = 1'b0;
    #1;
    checks++; if (ser_empty !== 1'b1) begin errors++; $display("FAIL pp_pop_empty got %b exp 1", ser_empty); end
    hit_empty = 1'b0;
    @(negedge clk);
    hit_empty = 1'b1;
    #1;
    checks++; if (ser_empty !== 1'b0 || ser_rdata !== mk(1'b0, 1)) begin errors++; $display("FAIL pp_ptr got e%b %0h exp e0 %0h", ser_empty, ser_rdata, mk(1'b0, 1)); end
  endtask

  task automatic test_reset_full();
    do_reset();
    hit_empty = 1'b0; fill_empty = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (ser_aempty !== 1'b0) begin errors++; $display("FAIL rf_full got %b exp 0", ser_aempty); end
    rst = 1'b1;
    #1;
    checks++; if (ser_empty !== 1'b1 || ser_aempty !== 1'b1) begin errors++; $display("FAIL rf_empty got e%b a%b exp e1 a1", ser_empty, ser_aempty); end
    checks++; if (ser_rdata !== 518'd0 || ser_src !== 1'b0) begin errors++; $display("FAIL rf_data got %b:%0h exp 0:0", ser_src, ser_rdata); end
    checks++; if (hit_rden !== 1'b0 || fill_rden !== 1'b0) begin errors++; $display("FAIL rf_rden got %b%b exp 00", hit_rden, fill_rden); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (hit_rden !== 1'b1 || fill_rden !== 1'b0) begin errors++; $display("FAIL rf_tie got %b%b exp 10", hit_rden, fill_rden); end
    @(negedge clk);
    hit_empty = 1'b1; fill_empty = 1'b1;
    #1;
    checks++; if (ser_src !== 1'b0 || ser_rdata !== mk(1'b0, 0)) begin errors++; $display("FAIL rf_head got %b:%0h exp 0:%0h", ser_src, ser_rdata, mk(1'b0, 0)); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    hit_empty = 1'b1; fill_empty = 1'b1; ser_rden = 1'b0;
    use_custom = 1'b0; custom_hit = '0;
    fp_hit_empty = 1'b1; fp_fill_empty = 1'b1; fp_ser_rden = 1'b0;
    fp_hit_rdata = mk(1'b0, 40); fp_fill_rdata = mk(1'b1, 41);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_hit();
    test_round_robin();
    test_fill_prio();
    test_full_buffer();
    test_push_pop();
    test_reset_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cc_rresp_arbiter.md
# cc_rresp_arbiter

Read-response scheduler in front of the cache controller's R-channel serializer. It arbitrates between two show-ahead line FIFOs, the hit-data FIFO and the miss-fill FIFO, and moves whole 518-bit line entries (6-bit critical-word offset + 512-bit line) into a small output buffer. The buffer presents a single FIFO-style read interface to the serializer, so the serializer drains one line per burst with back-to-back bursts and never sees a partial switch between sources.

## Interface
- DEPTH, 2: output buffer entries (2 or 4).
- FILL_PRIO, 0: 0 = round-robin; 1 = fill source wins ties, with a starvation limit.
- MAX_STREAK, 4: maximum consecutive fill grants while hit is waiting (FILL_PRIO=1 only); range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- hit_empty_i  in  1  hit FIFO empty.
- hit_rdata_i  in  518  hit FIFO head entry, show-ahead: {offset[5:0], line[511:0]}.
- hit_rden_o  out  1  pop hit FIFO (1-cycle pulse per entry).
- fill_empty_i  in  1  fill FIFO empty.
- fill_rdata_i  in  518  fill FIFO head entry, show-ahead.
- fill_rden_o  out  1  pop fill FIFO.
- ser_empty_o  out  1  output buffer empty.
- ser_aempty_o  out  1  output buffer holds ≤1 entry.
- ser_rdata_o  out  518  output buffer head entry.
- ser_src_o  out  1  source of head entry: 0 = hit, 1 = fill.
- ser_rden_i  in  1  serializer pops head entry.

## Operation
- Storage: DEPTH × 519-bit entries {src, rdata}, wr_ptr/rd_ptr, and a count register (0..DEPTH).
- space = (count < DEPTH). This uses the registered count only; a pop in the same cycle does not create extra space in that cycle.
- Request: req_h = !hit_empty_i, req_f = !fill_empty_i.
- Grant is combinational each cycle and is only valid when space=1:
  - Only one request: grant it.
  - Both requesting, FILL_PRIO=0: grant the source not in last_grant.
  - Both requesting, FILL_PRIO=1: grant fill unless streak == MAX_STREAK; in that case grant hit.
- hit_rden_o = space & grant_h. fill_rden_o = space & grant_f. At most one of the two is high in any cycle.
- Push, on the same edge as the rden: write {src, granted rdata} at wr_ptr, then wr_ptr++ (modulo DEPTH) and set last_grant = src.
- streak update on each grant:
  - +1 on a fill grant while req_h was high.
  - Cleared on any hit grant.
  - Cleared on a fill grant when req_h was low.
- Pop: ser_rden_i & (count != 0) → rd_ptr++. ser_rden_i while empty is ignored.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
- ser_empty_o = (count == 0). ser_aempty_o = (count ≤ 1). ser_rdata_o and ser_src_o come from the entry at rd_ptr.
- The offset field is carried through unmodified; the arbiter never reorders entries within a source.

## Timing
- Reset (async, immediate), output values:
  - ser_empty_o = 1, ser_aempty_o = 1.
  - ser_rdata_o = 0, ser_src_o = 0.
  - hit_rden_o = 0, fill_rden_o = 0.
- Reset, internal state:
  - count = 0, pointers = 0, streak = 0.
  - last_grant = fill, so the first tie goes to hit.
  - Storage cleared.
- Reset mid-operation discards all buffered entries. rden outputs drop combinationally while rst=1.
- Latency: source goes non-empty with the buffer empty → rden high in the same cycle → ser_empty_o low and data valid after the next edge (1 cycle).
- Throughput: one entry per cycle into the buffer. With DEPTH=2, the next line is already staged when the serializer pops at the end of a burst, giving zero idle cycles between bursts.
- Full buffer (count = DEPTH): both rden outputs are 0 even if ser_rden_i = 1 in that cycle. The refill happens one cycle after the pop.
- Source FIFO rdata is sampled only on the edge where the matching rden is high.

## Test plan
- Reset: assert rst mid-idle → all outputs at reset values. Deassert with hit_empty_i = 0 → hit_rden_o = 1 in the first cycle.
- Single hit entry {6'd3, 448'd…, 64'd777}, FILL_PRIO=0 → hit_rden_o pulses 1 cycle; next cycle ser_empty_o = 0, ser_rdata_o equals the entry, ser_src_o = 0. Then ser_rden_i pulse → ser_empty_o = 1.
- Both FIFOs always non-empty, FILL_PRIO=0, ser_rden_i every 8th cycle → buffer fills H, F, then one grant per pop, alternating H, F, H, F; count never exceeds 2.
- FILL_PRIO=1, MAX_STREAK=4, both always non-empty, continuous pops → grant sequence F, F, F, F, H, F, F, F, F, H.
- Full buffer (count = 2), sources non-empty, ser_rden_i = 1 → no rden that cycle; one rden the next cycle; count returns to 2.
- Push and pop in the same cycle at count = 1 → count stays 1, correct head order. ser_rden_i while empty → no pointer movement. rst asserted at count = 2 → ser_empty_o = 1 immediately.
